// File: rtl/sound_tone_generator.sv
// Square-wave tone engine driven by the sound sequencer. It turns a note code into
// PCM samples, switches notes only at half-period boundaries, and hands samples over valid/ready.
module sound_tone_generator #(
  parameter int unsigned                CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned                SAMPLE_DIV  = 1042,
  parameter int unsigned                SAMPLE_W    = 16,
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE   = 16'sh2000
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [3:0]                 sound,
  input  logic                       sound_enable,
  input  logic                       turbo_enable,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       playing,
  output logic                       overrun,
  input  logic                       clear_overrun
);

  localparam int unsigned       TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

  function automatic logic [15:0] note_freq(input logic [3:0] code);
    case (code)
      4'd1:    note_freq = 16'd262;
      4'd2:    note_freq = 16'd294;
      4'd3:    note_freq = 16'd330;
      4'd4:    note_freq = 16'd349;
      4'd5:    note_freq = 16'd392;
      4'd6:    note_freq = 16'd440;
      4'd7:    note_freq = 16'd494;
      4'd8:    note_freq = 16'd523;
      4'd9:    note_freq = 16'd587;
      4'd10:   note_freq = 16'd659;
      4'd11:   note_freq = 16'd698;
      4'd12:   note_freq = 16'd784;
      4'd13:   note_freq = 16'd880;
      4'd14:   note_freq = 16'd988;
      4'd15:   note_freq = 16'd1047;
      default: note_freq = 16'd0;
    endcase
  endfunction

  // Code 0 is silence and never loads the counter, so its entry stays 0.
  function automatic logic [15:0][23:0] build_half_table();
    logic [15:0][23:0] tbl;
    int unsigned       f;
    for (int i = 0; i < 16; i++) begin
      f = 32'(note_freq(4'(i)));
      if (f == 32'd0) begin
        tbl[i] = 24'd0;
      end else begin
        tbl[i] = 24'(CLK_FREQ_HZ / (32'd2 * f));
      end
    end
    return tbl;
  endfunction

  localparam logic [15:0][23:0] HALF_TABLE = build_half_table();

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t                     state_q;
  logic [23:0]                cnt_q;
  logic                       level_q;
  logic                       playing_q;
  logic [TICK_W-1:0]          tick_q, tick_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic                       req_s;
  logic                       tick_s;
  logic [23:0]                reload_s;
  logic signed [SAMPLE_W-1:0] inst_s;

  // Request decode and reload value taken from the inputs at the moment they are latched.
  always_comb begin
    req_s = sound_enable && (sound != 4'd0);
    if (turbo_enable) begin
      reload_s = (HALF_TABLE[sound] >> 1) - 24'd1;
    end else begin
      reload_s = HALF_TABLE[sound] - 24'd1;
    end
  end

  // Tone FSM: inputs are re-sampled only when the half-period counter expires.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cnt_q     <= 24'd0;
      level_q   <= 1'b1;
      playing_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            state_q   <= PLAY;
            cnt_q     <= reload_s;
            level_q   <= 1'b1;
            playing_q <= 1'b1;
          end
        end
        PLAY: begin
          if (cnt_q == 24'd0) begin
            if (req_s) begin
              level_q <= ~level_q;
              cnt_q   <= reload_s;
            end else begin
              level_q   <= 1'b1;
              state_q   <= IDLE;
              playing_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 24'd0;
          level_q   <= 1'b1;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  // Sample ticker plus output register handshake; an overwrite beats a simultaneous clear.
  always_comb begin
    inst_s = '0;
    if (state_q == PLAY) begin
      if (level_q) begin
        inst_s = AMPLITUDE;
      end else begin
        inst_s = -AMPLITUDE;
      end
    end else begin
      inst_s = '0;
    end

    tick_s = (tick_q == TICK_LAST);
    if (tick_s) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end

    sample_d = sample_q;
    if (tick_s) begin
      sample_d = inst_s;
      valid_d  = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end

    if (tick_s && valid_q && !sample_ready) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Sample path registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tick_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign playing      = playing_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sound_tone_generator.sv
// Self-checking bench for sound_tone_generator: per-cycle comparison against an
// event-time reference model, a half-period table, and hand-written corner sequences.
module tb_sound_tone_generator;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned DIV    = 10;
  localparam int          AMP    = 100;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic [3:0]        sound = 4'd6;
  logic              sound_enable = 1'b1;
  logic              turbo_enable = 1'b0;
  logic              sample_ready = 1'b1;
  logic              clear_overrun = 1'b0;
  logic signed [15:0] sample;
  logic              sample_valid;
  logic              playing;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sound_tone_generator #(
    .CLK_FREQ_HZ (CLK_HZ),
    .SAMPLE_DIV  (DIV),
    .SAMPLE_W    (16),
    .AMPLITUDE   (16'sd100)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .sound         (sound),
    .sound_enable  (sound_enable),
    .turbo_enable  (turbo_enable),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .playing       (playing),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  int freq_hz [0:15] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047};

  // Reference model: the tone is described by the absolute cycle of its next toggle.
  bit m_play, m_pos, m_valid, m_ovr;
  int m_sample, m_t, m_bound;

  function automatic int model_hp(int code, bit tb);
    int h;
    h = int'(CLK_HZ) / (2 * freq_hz[code]);
    return tb ? h / 2 : h;
  endfunction

  task automatic model_reset();
    m_play = 0; m_pos = 1; m_valid = 0; m_ovr = 0;
    m_sample = 0; m_t = 0; m_bound = 0;
  endtask

  task automatic model_edge();
    int inst;
    bit req, tick;
    inst = !m_play ? 0 : (m_pos ? AMP : -AMP);
    req  = sound_enable && (sound != 4'd0);
    tick = (m_t % int'(DIV)) == int'(DIV) - 1;
    if (tick && m_valid && !sample_ready) m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    if (tick) begin
      m_sample = inst;
      m_valid  = 1;
    end else if (m_valid && sample_ready) begin
      m_valid = 0;
    end
    if (!m_play) begin
      if (req) begin
        m_play = 1; m_pos = 1;
        m_bound = m_t + model_hp(int'(sound), turbo_enable);
      end
    end else if (m_t == m_bound) begin
      m_pos = !m_pos;
      if (req) m_bound = m_t + model_hp(int'(sound), turbo_enable);
      else m_play = 0;
    end
    m_t++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    checks++;
    if (int'(sample) != m_sample || sample_valid != m_valid || playing != m_play || overrun != m_ovr) begin
      errors++;
      $display("FAIL outputs@t=%0d: actual sample=%0d valid=%0b playing=%0b overrun=%0b required sample=%0d valid=%0b playing=%0b overrun=%0b",
               m_t, int'(sample), sample_valid, playing, overrun, m_sample, m_valid, m_play, m_ovr);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && playing; i++) step();
    check("idle_reached", int'(playing), 0);
  endtask

  typedef struct {
    logic [3:0] code;
    bit         turbo;
    int         exp_hp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'd6,  1'b0, 1136};
    vecs[1] = '{4'd6,  1'b1, 568};
    vecs[2] = '{4'd1,  1'b0, 1908};
    vecs[3] = '{4'd1,  1'b1, 954};
    vecs[4] = '{4'd15, 1'b0, 477};
    vecs[5] = '{4'd15, 1'b1, 238};
    vecs[6] = '{4'd13, 1'b0, 568};
    vecs[7] = '{4'd9,  1'b1, 425};

    // Reset held with an active request present.
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_overrun", int'(overrun), 0);
    resetN = 1'b1;
    steps(2);
    check("playing_after_release", int'(playing), 1);
    steps(2300);

    // Disable mid-tone: level holds to the boundary, then silence.
    sound_enable = 1'b0;
    wait_idle();
    steps(30);
    check("disable_silence_sample", int'(sample), 0);
    check("disable_playing", int'(playing), 0);

    // Half-period table: start a note and drop enable at once; playing lasts exactly one half.
    for (int v = 0; v < 8; v++) begin
      sound = vecs[v].code;
      turbo_enable = vecs[v].turbo;
      sound_enable = 1'b1;
      step();
      sound_enable = 1'b0;
      n = 0;
      for (int i = 0; i < 4000; i++) begin
        if (!playing) break;
        n++;
        step();
      end
      check($sformatf("half_code%0d_turbo%0d", vecs[v].code, vecs[v].turbo), n, vecs[v].exp_hp);
      steps(3);
    end

    // Turbo toggled mid-half-period.
    sound = 4'd6; turbo_enable = 1'b1; sound_enable = 1'b1;
    steps(200);
    turbo_enable = 1'b0;
    steps(2000);
    sound_enable = 1'b0;
    wait_idle();

    // Note change 6 -> 1 mid-half-period.
    sound = 4'd6; sound_enable = 1'b1;
    steps(500);
    sound = 4'd1;
    steps(3200);
    sound_enable = 1'b0;
    wait_idle();

    // Handshake: stalled reader, clear, then clear colliding with a set.
    sound = 4'd3; sound_enable = 1'b1; sample_ready = 1'b1;
    steps(40);
    sample_ready = 1'b0;
    steps(25);
    check("overrun_after_stall", int'(overrun), 1);
    sample_ready = 1'b1; clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("overrun_cleared", int'(overrun), 0);
    steps(3);
    sample_ready = 1'b0;
    for (int i = 0; i < 40 && !(m_valid && (m_t % int'(DIV)) == int'(DIV) - 1); i++) step();
    check("collision_setup", int'(overrun), 0);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("set_beats_clear", int'(overrun), 1);
    sample_ready = 1'b1;
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;

    // Asynchronous reset in the middle of a tone.
    steps(300);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("midreset_playing", int'(playing), 0);
    check("midreset_sample", int'(sample), 0);
    check("midreset_valid", int'(sample_valid), 0);
    sound_enable = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    steps(20);
    check("no_resume_without_request", int'(playing), 0);
    sound_enable = 1'b1;
    steps(2);
    check("resume_on_request", int'(playing), 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) sound = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) sound_enable = ~sound_enable;
      if ($urandom_range(0, 299) == 0) turbo_enable = ~turbo_enable;
      sample_ready  = ($urandom_range(0, 9) < 7);
      clear_overrun = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
